// File: rtl/cache_refill_unit.sv
// Cache line refill engine: optionally writes back a dirty victim line word by word,
// then reads the missing line from memory in ascending word order and presents it.
module cache_refill_unit #(
    parameter int unsigned TAG_W = 24,
    parameter int unsigned SET_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    input  logic                 victim_dirty,
    input  logic [TAG_W-1:0]     victim_tag,
    input  logic [255:0]         victim_line,
    output logic                 fill_valid,
    output logic [255:0]         fill_line,
    output logic [31:0]          fill_addr,
    output logic                 busy,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   k, k_nx;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_nx;
    logic [SET_W-1:0]   set_q, set_nx;
    logic [TAG_W-1:0]   vtag_q, vtag_nx;
    logic [255:0]       vline_q, vline_nx;

    logic               mem_we_d, mem_re_d, busy_d, fill_valid_d;
    logic [ADDR_W-1:0]  mem_addr_d, fill_addr_d;
    logic [WORD_W-1:0]  mem_wdata_d;

    // Byte offset of the missing address never reaches memory: transfers are whole lines.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFF_W-1:0];

    // State, word counter and the miss/victim context captured at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            miss_tag_q <= '0;
            set_q      <= '0;
            vtag_q     <= '0;
            vline_q    <= '0;
        end else begin
            state      <= state_nx;
            k          <= k_nx;
            miss_tag_q <= miss_tag_nx;
            set_q      <= set_nx;
            vtag_q     <= vtag_nx;
            vline_q    <= vline_nx;
        end
    end

    // Next state; requests arriving while busy are dropped, acks outside WB/RD are ignored
    always_comb begin
        state_nx    = state;
        k_nx        = k;
        miss_tag_nx = miss_tag_q;
        set_nx      = set_q;
        vtag_nx     = vtag_q;
        vline_nx    = vline_q;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    miss_tag_nx = miss_addr[ADDR_W-1 -: TAG_W];
                    set_nx      = miss_addr[OFF_W +: SET_W];
                    vtag_nx     = victim_tag;
                    vline_nx    = victim_line;
                    k_nx        = '0;
                    state_nx    = victim_dirty ? WB : RD;
                end
            end
            WB: begin
                if (mem_ack) begin
                    if (k == K_LAST) begin
                        k_nx     = '0;
                        state_nx = RD;
                    end else begin
                        k_nx = k + CNT_W'(1);
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    if (k == K_LAST) begin
                        k_nx     = '0;
                        state_nx = DONE;
                    end else begin
                        k_nx = k + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so registers track it
    always_comb begin
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr;
        busy_d       = (state_nx != IDLE);
        case (state_nx)
            WB: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {vtag_nx, set_nx, k_nx, 2'b00};
                mem_wdata_d = vline_nx[{k_nx, 5'd0} +: WORD_W];
            end
            RD: begin
                mem_re_d   = 1'b1;
                mem_addr_d = {miss_tag_nx, set_nx, k_nx, 2'b00};
            end
            DONE: begin
                fill_valid_d = 1'b1;
                fill_addr_d  = {miss_tag_nx, set_nx, OFF_W'(0)};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            busy       <= 1'b0;
        end else begin
            mem_we     <= mem_we_d;
            mem_re     <= mem_re_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            fill_valid <= fill_valid_d;
            fill_addr  <= fill_addr_d;
            busy       <= busy_d;
        end
    end

    // Read words land directly in the fill line; it then holds until the next refill
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_line <= '0;
        end else if (state == RD && mem_ack) begin
            fill_line[{k, 5'd0} +: WORD_W] <= mem_rdata;
        end
    end

endmodule

// File: doc/cache_refill_unit.md
CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 24, meaning tag width; address = {tag, set, 5-bit byte offset}.
REQ-002 SHALL have parameter SET_W, default 3, meaning set-index width; TAG_W+SET_W+5 SHALL equal 32.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 miss_req  input  1  cache reports a miss; sampled in IDLE only.
REQ-006 miss_addr  input  32  address that missed.
REQ-007 victim_dirty  input  1  selected victim way is dirty.
REQ-008 victim_tag  input  TAG_W  tag of victim line.
REQ-009 victim_line  input  256  victim line data, word k = bits [32k+31:32k].
REQ-010 fill_valid  output  1  one-cycle pulse, fill_line/fill_addr valid.
REQ-011 fill_line  output  256  assembled refill line.
REQ-012 fill_addr  output  32  line base of refilled line (offset bits 0).
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 mem_addr  output  32  word address to memory.
REQ-015 mem_wdata  output  32  write data to memory.
REQ-016 mem_we  output  1  write request, held until acked.
REQ-017 mem_re  output  1  read request, held until acked.
REQ-018 mem_rdata  input  32  read data, valid when mem_ack high during a read.
REQ-019 mem_ack  input  1  memory completes current word this cycle.

Function
REQ-020 SHALL implement states IDLE, WB, RD, DONE with a 3-bit word counter k.
REQ-021 IDLE: on miss_req=1, latch miss_addr, victim_dirty, victim_tag, victim_line; set k=0; go to WB if victim_dirty else RD.
REQ-022 miss_req in any state other than IDLE SHALL be ignored; there is no queueing.
REQ-023 WB: mem_we=1, mem_re=0, mem_addr={victim_tag, set, k, 2'b00}, mem_wdata=latched victim word k.
REQ-024 RD: mem_re=1, mem_we=0, mem_addr={miss tag, set, k, 2'b00}; set = latched miss_addr set field.
REQ-025 mem_addr, mem_wdata and request SHALL stay stable until the cycle mem_ack=1; that cycle completes word k.
REQ-026 On ack in WB: k<7 -> k+1; k=7 -> k=0, go to RD.
REQ-027 On ack in RD: store mem_rdata into fill_line word k; k<7 -> k+1; k=7 -> DONE.
REQ-028 Words SHALL be transferred in ascending order 0..7, with no critical-word-first ordering.
REQ-029 DONE: fill_valid=1 for exactly one cycle; fill_addr={miss tag, set, 5'b0}; next state IDLE.
REQ-030 fill_line and fill_addr SHALL hold their values after DONE until the next refill overwrites them.
REQ-031 mem_we and mem_re SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-032 mem_ack in IDLE or DONE SHALL be ignored.
REQ-033 Latency with zero-wait memory (ack in the request cycle): clean miss accepted at edge N -> fill_valid high in cycle N+9; dirty miss -> N+17.
REQ-034 Each memory wait cycle SHALL add exactly one cycle of latency.

Reset
REQ-035 Reset SHALL force IDLE, k=0, fill_valid=0, busy=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, fill_line=0, fill_addr=0.
REQ-036 Reset during WB/RD/DONE SHALL abort the transfer; no request is asserted in the cycle after reset.
REQ-037 Reset SHALL take priority over simultaneous miss_req or mem_ack.

Verification
REQ-038 Reset asserted 2 cycles -> all outputs 0, busy=0.
REQ-039 Clean miss, miss_addr=0x00001244, ack every cycle, rdata=0xA0000000+k -> mem_re with addrs 0x1240..0x125C; fill_line word k=0xA0000000+k; fill_addr=0x1240; fill_valid only at N+9.
REQ-040 Dirty miss, miss_addr=0x00001240, victim_tag=0x00ABCD, victim word k=0x5000000k -> 8 writes to 0xABCD40..0xABCD5C with data 0x5000000k, then 8 reads from 0x1240..0x125C; fill_valid at N+17.
REQ-041 Clean miss with mem_ack delayed 3 cycles per word -> mem_addr stable while unacked; fill_valid at N+33.
REQ-042 miss_req pulsed during RD -> ignored, exactly 8 reads issued; reset at WB word 3 -> next cycle IDLE, mem_we=0, no fill_valid.
